// File: rtl/timer_ctrl.sv
// Programmable timer: TIMA counts falling edges of the selected divider tap,
// with a delayed TMA reload and a one-cycle interrupt pulse on overflow.
module timer_ctrl #(
    parameter int OVF_DELAY = 4
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       tap_4096,
    input  logic       tap_262144,
    input  logic       tap_65536,
    input  logic       tap_16384,
    input  logic       sel_tima,
    input  logic       sel_tma,
    input  logic       sel_tac,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq_timer
);
    typedef enum logic [1:0] {IDLE, OVF, RELOAD} state_t;

    localparam logic [3:0] CNT_LAST = 4'(OVF_DELAY - 1);

    state_t     state_q;
    logic [7:0] tima_q, tma_q;
    logic [2:0] tac_q;
    logic       sig_d_q, irq_q;
    logic [3:0] cnt_q;

    logic       tap_sel, sig, inc;
    logic       wr_tima, wr_tma, wr_tac;

    always_comb begin
        tap_sel = 1'b0;
        case (tac_q[1:0])
            2'b00: tap_sel = tap_4096;
            2'b01: tap_sel = tap_262144;
            2'b10: tap_sel = tap_65536;
            2'b11: tap_sel = tap_16384;
            default: tap_sel = 1'b0;
        endcase
    end

    // Falling-edge detect on the gated tap; TAC changes can produce an edge too.
    assign sig     = tap_sel & tac_q[2];
    assign inc     = sig_d_q & ~sig;
    assign wr_tima = cpu_wr & sel_tima;
    assign wr_tma  = cpu_wr & sel_tma;
    assign wr_tac  = cpu_wr & sel_tac;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            tima_q  <= 8'h00;
            tma_q   <= 8'h00;
            tac_q   <= 3'b000;
            sig_d_q <= 1'b0;
            irq_q   <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            sig_d_q <= sig;
            irq_q   <= 1'b0;
            if (wr_tma) tma_q <= din;
            if (wr_tac) tac_q <= din[2:0];
            case (state_q)
                IDLE: begin
                    if (wr_tima) begin
                        tima_q <= din;
                    end else if (inc) begin
                        if (tima_q == 8'hFF) begin
                            tima_q  <= 8'h00;
                            state_q <= OVF;
                            cnt_q   <= 4'd0;
                        end else begin
                            tima_q <= tima_q + 8'd1;
                        end
                    end
                end
                OVF: begin
                    if (wr_tima) begin
                        tima_q  <= din;
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == CNT_LAST) begin
                        tima_q  <= tma_q;
                        state_q <= RELOAD;
                        irq_q   <= 1'b1;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        if (inc) tima_q <= tima_q + 8'd1;
                    end
                end
                RELOAD: begin
                    // TIMA writes are dropped here; a TMA write lands in both.
                    state_q <= IDLE;
                    if (wr_tma) tima_q <= din;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        dout = 8'hFF;
        if (cpu_rd) begin
            if (sel_tima)     dout = tima_q;
            else if (sel_tma) dout = tma_q;
            else if (sel_tac) dout = {5'b11111, tac_q};
        end
    end

    assign irq_timer = irq_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: directed scenarios plus random traffic,
// compared cycle by cycle against a behavioural countdown model.
module tb_timer_ctrl;
    localparam int DLY = 4;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       tap_4096 = 1'b0, tap_262144 = 1'b0, tap_65536 = 1'b0, tap_16384 = 1'b0;
    logic       sel_tima = 1'b0, sel_tma = 1'b0, sel_tac = 1'b0;
    logic       cpu_wr = 1'b0, cpu_rd = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] dout;
    logic       irq_timer;

    timer_ctrl #(.OVF_DELAY(DLY)) dut (
        .clk(clk), .nreset(nreset),
        .tap_4096(tap_4096), .tap_262144(tap_262144),
        .tap_65536(tap_65536), .tap_16384(tap_16384),
        .sel_tima(sel_tima), .sel_tma(sel_tma), .sel_tac(sel_tac),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .din(din),
        .dout(dout), .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: countdown > 0 means an overflow reload is pending.
    logic [7:0] m_tima, m_tma;
    logic [2:0] m_tac;
    logic       m_prev, m_irq, m_rl;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tima = 8'h00; m_tma = 8'h00; m_tac = 3'b000;
        m_prev = 1'b0; m_irq = 1'b0; m_rl = 1'b0; m_cnt = 0;
    endtask

    task automatic model_step(input logic wr, input int rs, input logic [7:0] d, input logic [3:0] tp);
        logic sig, inc, n_irq, n_rl, wt, wm, wc;
        logic [7:0] tma_old;
        sig = tp[m_tac[1:0]] & m_tac[2];
        inc = m_prev & ~sig;
        n_irq = 1'b0; n_rl = 1'b0; tma_old = m_tma;
        wt = wr && rs == 1; wm = wr && rs == 2; wc = wr && rs == 3;
        if (m_rl) begin
            if (wm) m_tima = d;
        end else if (m_cnt > 0) begin
            if (wt) begin
                m_tima = d; m_cnt = 0;
            end else if (m_cnt == 1) begin
                m_tima = tma_old; m_cnt = 0; n_irq = 1'b1; n_rl = 1'b1;
            end else begin
                if (inc) m_tima = m_tima + 8'd1;
                m_cnt--;
            end
        end else begin
            if (wt) m_tima = d;
            else if (inc) begin
                if (m_tima == 8'hFF) begin m_tima = 8'h00; m_cnt = DLY; end
                else m_tima = m_tima + 8'd1;
            end
        end
        if (wm) m_tma = d;
        if (wc) m_tac = d[2:0];
        m_prev = sig; m_irq = n_irq; m_rl = n_rl;
    endtask

    task automatic step(input logic wr, input int rs, input logic [7:0] d, input logic [3:0] tp, input logic rd);
        logic [7:0] exp_rd;
        @(negedge clk);
        cpu_wr = wr; din = d; cpu_rd = rd;
        sel_tima = (rs == 1); sel_tma = (rs == 2); sel_tac = (rs == 3);
        {tap_16384, tap_65536, tap_262144, tap_4096} = tp;
        #1;
        exp_rd = !rd ? 8'hFF : rs == 1 ? m_tima : rs == 2 ? m_tma :
                 rs == 3 ? {5'b11111, m_tac} : 8'hFF;
        check("dout_rd", {24'd0, dout}, {24'd0, exp_rd});
        model_step(wr, rs, d, tp);
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b1; sel_tima = 1'b1; sel_tma = 1'b0; sel_tac = 1'b0;
        #1;
        check("tima", {24'd0, dout}, {24'd0, m_tima});
        check("irq", {31'd0, irq_timer}, {31'd0, m_irq});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 8'h00, 4'b0000, 1'b0);
    endtask

    task automatic read_reg(input int rs, output logic [7:0] v);
        cpu_wr = 1'b0; cpu_rd = 1'b1;
        sel_tima = (rs == 1); sel_tma = (rs == 2); sel_tac = (rs == 3);
        #1 v = dout;
    endtask

    task automatic do_reset();
        logic [7:0] v;
        @(negedge clk);
        #2 nreset = 1'b0;
        #1;
        read_reg(1, v); check("rst_tima", {24'd0, v}, 32'h00);
        read_reg(2, v); check("rst_tma", {24'd0, v}, 32'h00);
        read_reg(3, v); check("rst_tac", {24'd0, v}, 32'hF8);
        check("rst_irq", {31'd0, irq_timer}, 32'd0);
        cpu_rd = 1'b0; #1;
        check("rst_dout_idle", {24'd0, dout}, 32'hFF);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        nreset = 1'b1;
    endtask

    // Rising then falling edge on tap_262144 (needs TAC=3'b101).
    task automatic ovf_edge();
        step(1'b0, 0, 8'h00, 4'b0010, 1'b0);
        step(1'b0, 0, 8'h00, 4'b0000, 1'b0);
    endtask

    task automatic wait_reload();
        for (int i = 0; i < 20 && !m_rl; i++) idle(1);
        if (!m_rl) check("reload_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        model_reset();
        do_reset();

        // Basic count on tap_262144
        step(1'b1, 3, 8'h05, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) ovf_edge();
        read_reg(1, v); check("count3", {24'd0, v}, 32'h03);
        check("count3_irq", {31'd0, irq_timer}, 32'd0);

        // Overflow with delayed reload
        step(1'b1, 2, 8'hA0, 4'b0000, 1'b0);
        step(1'b1, 1, 8'hFF, 4'b0000, 1'b0);
        ovf_edge();
        read_reg(1, v); check("ovf_zero", {24'd0, v}, 32'h00);
        idle(DLY);
        read_reg(1, v); check("ovf_reload", {24'd0, v}, 32'hA0);
        check("ovf_irq", {31'd0, irq_timer}, 32'd1);
        idle(2);

        // Cancel by TIMA write two cycles into overflow
        step(1'b1, 1, 8'hFF, 4'b0000, 1'b0);
        ovf_edge();
        idle(1);
        step(1'b1, 1, 8'h33, 4'b0000, 1'b0);
        idle(6);
        read_reg(1, v); check("cancel_tima", {24'd0, v}, 32'h33);

        // Writes during the reload cycle
        step(1'b1, 1, 8'hFF, 4'b0000, 1'b0);
        ovf_edge();
        wait_reload();
        step(1'b1, 1, 8'h55, 4'b0000, 1'b0);
        read_reg(1, v); check("rl_tima_wr", {24'd0, v}, 32'hA0);
        step(1'b1, 1, 8'hFF, 4'b0000, 1'b0);
        ovf_edge();
        wait_reload();
        check("rl_irq", {31'd0, irq_timer}, 32'd1);
        step(1'b1, 2, 8'h77, 4'b0000, 1'b0);
        read_reg(1, v); check("rl_tma_tima", {24'd0, v}, 32'h77);
        read_reg(2, v); check("rl_tma_tma", {24'd0, v}, 32'h77);

        // TAC glitch increments
        step(1'b1, 1, 8'h10, 4'b0001, 1'b0);
        step(1'b1, 3, 8'h04, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h00, 4'b0001, 1'b0);
        step(1'b1, 3, 8'h00, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h00, 4'b0001, 1'b0);
        step(1'b0, 0, 8'h00, 4'b0001, 1'b0);
        read_reg(1, v); check("glitch_one", {24'd0, v}, 32'h11);
        step(1'b1, 3, 8'h04, 4'b0000, 1'b0);
        step(1'b0, 0, 8'h00, 4'b0000, 1'b0);
        step(1'b1, 3, 8'h00, 4'b0000, 1'b0);
        idle(2);
        read_reg(1, v); check("glitch_none", {24'd0, v}, 32'h11);

        // Reset during overflow
        step(1'b1, 3, 8'h05, 4'b0000, 1'b0);
        step(1'b1, 1, 8'hFF, 4'b0000, 1'b0);
        ovf_edge();
        idle(1);
        do_reset();
        idle(8);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic       wr, rd;
            int         rs;
            logic [7:0] d;
            logic [3:0] tp;
            if ($urandom_range(0, 199) == 0) do_reset();
            wr = ($urandom_range(0, 3) == 0);
            rs = $urandom_range(0, 3);
            d  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            tp = 4'($urandom);
            rd = 1'($urandom);
            step(wr, rs, d, tp, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL provide parameter OVF_DELAY, default 4, meaning the number of clk cycles TIMA holds 8'h00 after overflow before reload (legal range 1..15).
REQ-002 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port nreset  in  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports tap_4096, tap_262144, tap_65536, tap_16384  in  1 each  divider tap levels from the system divider.
REQ-005 SHALL have ports sel_tima, sel_tma, sel_tac  in  1 each  decoded register selects for FF05, FF06 and FF07; at most one is high at a time.
REQ-006 SHALL have ports cpu_wr and cpu_rd  in  1 each  write strobe (one clk cycle per write) and read enable.
REQ-007 SHALL have port din  in  8  write data.
REQ-008 SHALL have port dout  out  8  read data.
REQ-009 SHALL have port irq_timer  out  1  one-cycle timer interrupt request pulse.

Function
REQ-010 SHALL hold registers TIMA[7:0], TMA[7:0], TAC[2:0], a tap-history flop sig_d, and a state machine with states IDLE, OVF and RELOAD plus an OVF cycle counter.
REQ-011 SHALL select the tap from registered TAC[1:0]: 00 -> tap_4096, 01 -> tap_262144, 10 -> tap_65536, 11 -> tap_16384.
REQ-012 SHALL form sig = selected_tap AND TAC[2], register it into sig_d every cycle, and assert inc when sig_d=1 and sig=0.
REQ-013 SHALL produce an increment when clearing TAC[2] or changing TAC[1:0] turns sig from 1 to 0; this deliberate glitch is part of the specified behaviour.
REQ-014 SHALL apply a TAC write at the next edge, so its effect on sig is visible from the following cycle.
REQ-015 SHALL, in IDLE on inc, set TIMA to TIMA+1 when TIMA < 8'hFF; when TIMA = 8'hFF, it SHALL set TIMA to 8'h00 and enter OVF.
REQ-016 SHALL hold OVF for exactly OVF_DELAY cycles, then enter RELOAD for exactly one cycle, then return to IDLE.
REQ-017 SHALL, on entering RELOAD, load TIMA from TMA and drive irq_timer high for that cycle only, with irq_timer low in all other cycles.
REQ-018 SHALL, on inc during OVF, increment TIMA normally (8'h00 -> 8'h01) without restarting the delay; the reload still overwrites TIMA.
REQ-019 SHALL, on a TIMA write in IDLE, load din into TIMA, and the write SHALL win over a simultaneous inc, which is dropped.
REQ-020 SHALL, on a TIMA write during OVF, load din into TIMA, cancel the reload and the IRQ, and return to IDLE.
REQ-021 SHALL ignore a TIMA write in the RELOAD cycle, so TIMA equals TMA.
REQ-022 SHALL, on a TMA write in the RELOAD cycle, store din in TMA and also load din into TIMA.
REQ-023 SHALL drive dout combinationally when cpu_rd is high: TIMA for sel_tima, TMA for sel_tma, {5'b11111,TAC} for sel_tac, and 8'hFF otherwise.
REQ-024 SHALL return 8'h00 (or the incremented value) for a TIMA read during OVF.
REQ-025 SHALL wrap all arithmetic modulo 256, and SHALL never produce irq_timer on a CPU write of any value.

Reset
REQ-026 SHALL, while nreset is low, force TIMA=8'h00, TMA=8'h00, TAC=3'b000, sig_d=0, state IDLE, OVF counter 0 and irq_timer=0, with no dependence on clk.
REQ-027 SHALL, on reset asserted in OVF or RELOAD, abort the sequence, so no irq_timer pulse follows the release of reset.
REQ-028 SHALL, after nreset rises, count only from the first falling edge of sig seen after release, because sig_d restarts at 0.

Verification
REQ-029 SHALL cover basic count: TAC=3'b101, toggle tap_262144 for 3 falling edges -> TIMA=8'h03, irq_timer=0.
REQ-030 SHALL cover overflow: TMA=8'hA0, TIMA=8'hFF, one falling edge at cycle N -> TIMA=8'h00 for cycles N+1..N+4, then TIMA=8'hA0 and irq_timer=1 at N+5 only.
REQ-031 SHALL cover cancel: overflow at N, TIMA write 8'h33 at N+2 -> TIMA=8'h33, no irq, TMA not loaded.
REQ-032 SHALL cover reload-cycle writes: TIMA write 8'h55 in RELOAD -> TIMA=TMA; TMA write 8'h77 in RELOAD -> TMA=TIMA=8'h77, irq_timer=1.
REQ-033 SHALL cover the TAC glitch: TAC=3'b100, tap_4096 held 1, write TAC=3'b000 -> exactly one increment; write while tap is 0 -> none.
REQ-034 SHALL cover reset mid-OVF: pulse nreset low at N+2 -> all registers 0, dout=8'hFF with cpu_rd low, no irq_timer pulse afterwards.
